// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, the default
// memory-wait timeout and the wait-counter helpers. The pipeline top
// imports this package as well, so the encodings seen on the state port
// always match what the rest of the pipeline expects.
package hazard_ctrl_pkg;

  // Hazard FSM states; the numeric values are visible on the state port
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } hz_state_t;

  // Default number of MEM_WAIT cycles before mem_timeout is raised
  localparam int MEM_TIMEOUT_DEFAULT = 255;

  // Width and ceiling of the internal memory-wait counter
  localparam int          WAIT_CNT_W   = 16;
  localparam logic [15:0] WAIT_CNT_MAX = 16'hFFFF;

  // Increment that sticks at the top value instead of rolling over
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == WAIT_CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Free-running performance counter: counts cycles where en is high and
// wraps naturally at 2^CNT_W. Cleared asynchronously by rst.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // Count qualifying cycles; overflow simply wraps back to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Decides each cycle which pipeline registers
// hold, which receive a NOP bubble, and tracks a small FSM so a load-use
// hazard produces exactly one bubble and a memory stall is remembered
// across cycles. Priority is memory stall, then branch redirect, then
// load-use. Control outputs are combinational; state, counters and the
// sticky timeout flag are registered.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_rs1,
  input  logic             load_use_rs2,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(MEM_TIMEOUT);

  hz_state_t             cur_state;
  hz_state_t             next_state;
  logic                  mem_stall;
  logic                  load_use;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_next;
  logic                  timeout_hit;
  logic                  flush_any;

  assign mem_stall = mem_req & ~mem_ready;
  assign load_use  = load_use_rs1 | load_use_rs2;
  assign state     = cur_state;
  assign flush_any = ifid_flush | idex_flush;

  // Priority decode of control outputs and next state; a MEM_WAIT that is
  // released this cycle falls through to the same rules as RUN, so a branch
  // held in EX during the wait takes effect on the release cycle. All
  // controls are held low while reset is asserted.
  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    exmem_stall  = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    next_state   = ST_RUN;

    if (mem_stall) begin
      pc_stall     = 1'b1;
      ifid_stall   = 1'b1;
      idex_stall   = 1'b1;
      exmem_stall  = 1'b1;
      memwb_bubble = 1'b1;
      next_state   = ST_MEM_WAIT;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_RUN;
    end else if (load_use && (cur_state != ST_LU_BUBBLE)) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
      next_state = ST_LU_BUBBLE;
    end

    if (rst) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      idex_stall   = 1'b0;
      exmem_stall  = 1'b0;
      ifid_flush   = 1'b0;
      idex_flush   = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  // Next wait count: count up while waiting, restart from zero on entry
  always_comb begin
    wait_next = wait_cnt;
    if (cur_state == ST_MEM_WAIT) begin
      wait_next = sat_inc16(wait_cnt);
    end else if (next_state == ST_MEM_WAIT) begin
      wait_next = '0;
    end
  end

  assign timeout_hit = (cur_state == ST_MEM_WAIT) && (wait_next == TIMEOUT_VAL);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= ST_RUN;
    end else begin
      cur_state <= next_state;
    end
  end

  // Wait counter and sticky timeout flag; the flag rises on the same edge
  // the counter reaches the limit and only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt <= wait_next;
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_stall),
    .count (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush_any),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. A driver issues one input pattern per cycle,
// asks a behavioural model what the DUT should show during that cycle and
// queues it; a monitor on the falling edge pops and compares. Reset
// behaviour is checked directly between clock edges.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          load_use_rs1;
  logic          load_use_rs2;
  logic          ex_branch_taken;
  logic          mem_req;
  logic          mem_ready;
  logic          pc_stall;
  logic          ifid_stall;
  logic          idex_stall;
  logic          exmem_stall;
  logic          ifid_flush;
  logic          idex_flush;
  logic          memwb_bubble;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
  logic          mem_timeout;

  typedef struct {
    logic [6:0]    ctrl;
    logic [1:0]    st;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          to;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // model of the hazard unit's observable behaviour
  bit m_waiting;
  bit m_in_bubble;
  bit m_timeout;
  int m_wait_cycles;
  int m_stalls;
  int m_flushes;
  bit p_lu;
  bit p_br;
  bit p_mreq;
  bit p_mrdy;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .load_use_rs1    (load_use_rs1),
    .load_use_rs2    (load_use_rs2),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .ifid_stall      (ifid_stall),
    .idex_stall      (idex_stall),
    .exmem_stall     (exmem_stall),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .state           (state),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout     (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] dut_ctrl();
    return {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, memwb_bubble};
  endfunction

  // order: pc, ifid, idex, exmem stalls, ifid, idex flushes, memwb bubble
  function automatic logic [6:0] model_ctrl(bit lu, bit br, bit mreq, bit mrdy);
    if (mreq && !mrdy) return 7'b1111001;
    if (br) return 7'b0000110;
    if (lu && !m_in_bubble) return 7'b1100010;
    return 7'b0000000;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_waiting) return 2'd2;
    if (m_in_bubble) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_waiting     = 0;
    m_in_bubble   = 0;
    m_timeout     = 0;
    m_wait_cycles = 0;
    m_stalls      = 0;
    m_flushes     = 0;
    p_lu          = 0;
    p_br          = 0;
    p_mreq        = 0;
    p_mrdy        = 0;
  endtask

  // advance the model across one clock edge using the inputs of the cycle just ended
  task automatic model_step();
    logic [6:0] c;
    bit ms;
    c  = model_ctrl(p_lu, p_br, p_mreq, p_mrdy);
    ms = p_mreq && !p_mrdy;
    if (m_waiting) begin
      if (m_wait_cycles < 65535) m_wait_cycles++;
      if (m_wait_cycles == TO) m_timeout = 1;
    end else if (ms) begin
      m_wait_cycles = 0;
    end
    m_in_bubble = !ms && !p_br && p_lu && !m_in_bubble;
    m_waiting   = ms;
    if (c[6]) m_stalls++;
    if (c[2] || c[1]) m_flushes++;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(bit lu1, bit lu2, bit br, bit mreq, bit mrdy);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    load_use_rs1    = lu1;
    load_use_rs2    = lu2;
    ex_branch_taken = br;
    mem_req         = mreq;
    mem_ready       = mrdy;
    p_lu   = lu1 || lu2;
    p_br   = br;
    p_mreq = mreq;
    p_mrdy = mrdy;
    e.ctrl = model_ctrl(p_lu, p_br, p_mreq, p_mrdy);
    e.st   = model_state();
    e.sc   = m_stalls[CW-1:0];
    e.fc   = m_flushes[CW-1:0];
    e.to   = m_timeout;
    sb_q.push_back(e);
  endtask

  task automatic set_idle();
    load_use_rs1    = 1'b0;
    load_use_rs2    = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 set_idle();
    #1 rst = 1'b0;
    model_reset();
  endtask

  // reset landing in the middle of a cycle; everything must clear before the next edge
  task automatic reset_mid_cycle();
    @(posedge clk);
    model_step();
    #1;
    check_output("pre_reset_state", state, model_state());
    #1 rst = 1'b1;
    #1;
    check_output("rst_state", state, 2'd0);
    check_output("rst_ctrl", dut_ctrl(), 7'd0);
    check_output("rst_stall_cnt", stall_cnt, 0);
    check_output("rst_flush_cnt", flush_cnt, 0);
    check_output("rst_timeout", mem_timeout, 1'b0);
  endtask

  // scoreboard monitor: compare whatever the driver queued for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("ctrl", dut_ctrl(), e.ctrl);
        check_output("state", state, e.st);
        check_output("stall_cnt", stall_cnt, e.sc);
        check_output("flush_cnt", flush_cnt, e.fc);
        check_output("mem_timeout", mem_timeout, e.to);
      end
    end
  end

  initial begin
    rst             = 1'b1;
    load_use_rs1    = 1'b1;
    load_use_rs2    = 1'b0;
    ex_branch_taken = 1'b1;
    mem_req         = 1'b1;
    mem_ready       = 1'b0;
    model_reset();
    #3;
    check_output("init_state", state, 2'd0);
    check_output("init_ctrl", dut_ctrl(), 7'd0);
    check_output("init_stall_cnt", stall_cnt, 0);
    check_output("init_flush_cnt", flush_cnt, 0);
    check_output("init_timeout", mem_timeout, 1'b0);
    release_reset();

    // load-use held two cycles gives a single bubble
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);

    // branch wins over a concurrent load-use
    apply_stimulus(0, 1, 1, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);

    // three-cycle memory stall then release
    repeat (3) apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1);

    // branch held through a wait takes effect on release
    repeat (2) apply_stimulus(0, 0, 1, 1, 0);
    apply_stimulus(0, 0, 1, 1, 1);
    apply_stimulus(0, 0, 0, 0, 1);

    // long wait raises the sticky timeout
    repeat (6) apply_stimulus(0, 0, 0, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1);
    repeat (2) apply_stimulus(0, 0, 0, 0, 1);

    // sixteen load-use stalls wrap the 4-bit stall counter
    repeat (16) begin
      apply_stimulus(0, 1, 0, 0, 1);
      apply_stimulus(0, 0, 0, 0, 1);
    end

    // reset in the second MEM_WAIT cycle
    repeat (2) apply_stimulus(0, 0, 0, 1, 0);
    reset_mid_cycle();
    release_reset();
    apply_stimulus(0, 0, 0, 0, 1);

    // reset while the load-use bubble is pending
    apply_stimulus(1, 1, 0, 0, 1);
    reset_mid_cycle();
    release_reset();
    apply_stimulus(1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1);

    // randomized traffic
    repeat (500) begin
      apply_stimulus(($urandom % 3) == 0, ($urandom % 4) == 0, ($urandom % 5) == 0,
                     ($urandom % 2) == 0, ($urandom % 4) != 0);
    end

    @(negedge clk);
    #1;
    check_output("queue_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
